// File: rtl/srt4_ctrl_seq.sv
// -----------------------------------------------------------------------------
// srt4_ctrl_seq
//
// Control sequencer for the 8-bit radix-4 SRT divider. It walks the register
// stage (P, A, A', B) through init, normalize, ITER digit iterations, sign
// correction, quotient conversion and remainder denormalize. It does this by
// issuing one-cycle control pulses on ctrl[14:0].
//
// Timing model:
//   - A state visit lasts one clock. The visit makes its decisions from the
//     status inputs it sees during that visit.
//   - The pulses the visit asks for are registered, so they appear on ctrl in
//     the cycle that follows the visit.
//   - Counting the cycle after the edge that accepts start as cycle 0:
//     c0 appears at cycle 1, c1 at cycle 2, the NORM decision at cycle 3 and
//     the first SEL pulse at cycle 4.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   begin a division; accepted only when idle and not busy
//   b_msb   in   1   B[7]; 1 = divisor normalized
//   p_top   in   4   P[6:3], two's-complement estimate t used for digit select
//   p_sign  in   1   P[8], final remainder sign
//   ctrl    out  15  ctrl[i] = ci pulse
//   busy    out  1   high from the cycle after start is accepted until done
//   done    out  1   one-cycle pulse when the result is valid
//   err     out  1   divide-by-zero flag, held until the next accepted start
// -----------------------------------------------------------------------------
module srt4_ctrl_seq #(
    parameter int ITER     = 4,
    parameter int NORM_MAX = 7,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        b_msb,
    input  logic [3:0]  p_top,
    input  logic        p_sign,
    output logic [14:0] ctrl,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOADB,
        S_NORM,
        S_SEL,
        S_ADD,
        S_CHK,
        S_CORR,
        S_CINC,
        S_CONV,
        S_DEN,
        S_FIN
    } state_t;

    // Control bit positions.
    localparam int C_INIT  = 0;   // clear P and A', load A with the dividend
    localparam int C_LOADB = 1;   // load B
    localparam int C_NORM  = 2;   // shift P:A and B left by one
    localparam int C_SEL   = 3;   // digit-select strobe
    localparam int C_QP1   = 4;   // digit +1
    localparam int C_QM1   = 5;   // digit -1
    localparam int C_QM2   = 6;   // digit -2
    localparam int C_QP2   = 7;   // digit +2
    localparam int C_ADD   = 8;   // P add/sub enable
    localparam int C_SUB   = 9;   // subtract (positive digit)
    localparam int C_TWOB  = 10;  // use 2B as the operand
    localparam int C_CORR  = 11;  // correction add P <= P + B
    localparam int C_CINC  = 12;  // A' <= A' + 1
    localparam int C_CONV  = 13;  // A <= A - A'
    localparam int C_DEN   = 14;  // remainder denormalize shift

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] NORM_LIM  = CNT_W'(NORM_MAX);

    state_t            state_q, state_d;
    logic [14:0]       ctrl_q, ctrl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic [CNT_W-1:0]  ncnt_q, ncnt_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;

    // The digit chosen in SEL is remembered for the following ADD visit.
    // It is stored as three flags:
    //   q_nz  - the digit is nonzero
    //   q_pos - the digit is positive, so ADD subtracts
    //   q_two - the magnitude is 2, so ADD uses 2B
    logic              q_nz_q, q_nz_d;
    logic              q_pos_q, q_pos_d;
    logic              q_two_q, q_two_d;

    logic signed [3:0] t_est;

    assign t_est = signed'(p_top);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        icnt_d  = icnt_q;
        ncnt_d  = ncnt_q;
        dcnt_d  = dcnt_q;
        q_nz_d  = q_nz_q;
        q_pos_d = q_pos_q;
        q_two_d = q_two_q;

        case (state_q)
            S_IDLE: begin
                // busy is still high in the cycle that carries done.
                // A start seen in that cycle is ignored.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    state_d = S_INIT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end

            S_INIT: begin
                ctrl_d[C_INIT] = 1'b1;
                icnt_d         = '0;
                ncnt_d         = '0;
                dcnt_d         = '0;
                state_d        = S_LOADB;
            end

            S_LOADB: begin
                ctrl_d[C_LOADB] = 1'b1;
                state_d         = S_NORM;
            end

            S_NORM: begin
                if (b_msb) begin
                    state_d = S_SEL;
                end else if (ncnt_q == NORM_LIM) begin
                    // The divisor never normalized, so it is zero.
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    ctrl_d[C_NORM] = 1'b1;
                    ncnt_d         = ncnt_q + 1'b1;
                end
            end

            S_SEL: begin
                ctrl_d[C_SEL] = 1'b1;
                if (t_est >= 4'sd3) begin
                    ctrl_d[C_QP2] = 1'b1;
                    q_nz_d  = 1'b1;
                    q_pos_d = 1'b1;
                    q_two_d = 1'b1;
                end else if (t_est >= 4'sd1) begin
                    ctrl_d[C_QP1] = 1'b1;
                    q_nz_d  = 1'b1;
                    q_pos_d = 1'b1;
                    q_two_d = 1'b0;
                end else if (t_est >= -4'sd1) begin
                    q_nz_d  = 1'b0;
                    q_pos_d = 1'b0;
                    q_two_d = 1'b0;
                end else if (t_est >= -4'sd3) begin
                    ctrl_d[C_QM1] = 1'b1;
                    q_nz_d  = 1'b1;
                    q_pos_d = 1'b0;
                    q_two_d = 1'b0;
                end else begin
                    ctrl_d[C_QM2] = 1'b1;
                    q_nz_d  = 1'b1;
                    q_pos_d = 1'b0;
                    q_two_d = 1'b1;
                end
                state_d = S_ADD;
            end

            S_ADD: begin
                // A zero digit leaves P untouched.
                // The sub and 2B selects only ever ride along with the add enable.
                if (q_nz_q) begin
                    ctrl_d[C_ADD]  = 1'b1;
                    ctrl_d[C_SUB]  = q_pos_q;
                    ctrl_d[C_TWOB] = q_two_q;
                end
                icnt_d = icnt_q + 1'b1;
                if (icnt_q == ITER_LAST) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_SEL;
                end
            end

            S_CHK: begin
                state_d = p_sign ? S_CORR : S_CONV;
            end

            S_CORR: begin
                ctrl_d[C_ADD]  = 1'b1;
                ctrl_d[C_CORR] = 1'b1;
                state_d        = S_CINC;
            end

            S_CINC: begin
                ctrl_d[C_CINC] = 1'b1;
                state_d        = S_CONV;
            end

            S_CONV: begin
                ctrl_d[C_CONV] = 1'b1;
                state_d        = S_DEN;
            end

            S_DEN: begin
                // Undo exactly as many shifts as normalization applied.
                if (dcnt_q < ncnt_q) begin
                    ctrl_d[C_DEN] = 1'b1;
                    dcnt_d        = dcnt_q + 1'b1;
                end else begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            icnt_q  <= '0;
            ncnt_q  <= '0;
            dcnt_q  <= '0;
            q_nz_q  <= 1'b0;
            q_pos_q <= 1'b0;
            q_two_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            icnt_q  <= icnt_d;
            ncnt_q  <= ncnt_d;
            dcnt_q  <= dcnt_d;
            q_nz_q  <= q_nz_d;
            q_pos_q <= q_pos_d;
            q_two_q <= q_two_d;
        end
    end

    assign ctrl = ctrl_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_srt4_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_srt4_ctrl_seq
//
// Directed bench for srt4_ctrl_seq.
//   - Each run accepts one start and then samples ctrl, busy, done and err on
//     every falling edge until done appears.
//   - The cycle after the accepting edge is cycle 0.
//   - Expected pulse positions are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_srt4_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        b_msb = 1'b0;
    logic [3:0]  p_top = 4'h0;
    logic        p_sign = 1'b0;
    logic [14:0] ctrl;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] tr_ctrl [0:63];
    logic        tr_err  [0:63];
    logic        tr_busy [0:63];
    int          cnt     [0:14];
    int          inv_bad;
    int          done_cyc;

    // Expected ctrl trace, b_msb=1, digits +2,+1,0,-1, p_sign=0 (cycles 0..15).
    localparam logic [14:0] EXP_A [0:15] = '{
        15'h0000, 15'h0001, 15'h0002, 15'h0000,
        15'h0088, 15'h0700, 15'h0018, 15'h0300,
        15'h0008, 15'h0000, 15'h0028, 15'h0100,
        15'h0000, 15'h2000, 15'h0000, 15'h0000
    };

    srt4_ctrl_seq #(.ITER(4), .NORM_MAX(7), .CNT_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .b_msb  (b_msb),
        .p_top  (p_top),
        .p_sign (p_sign),
        .ctrl   (ctrl),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs for one run:
    //   nz   - number of NORM visits that see b_msb=0 before it is raised
    //          (8 keeps it low for the whole run)
    //   ptbl - p_top for SEL visit k, taken from nibble k
    //   psg  - p_sign value
    task automatic run(input string tag, input int nz, input logic [15:0] ptbl, input logic psg);
        int n2;
        int n3;
        int cyc;
        n2 = 0;
        n3 = 0;
        cyc = 0;
        inv_bad = 0;
        done_cyc = -1;
        for (int i = 0; i < 15; i++) cnt[i] = 0;
        for (int i = 0; i < 64; i++) begin
            tr_ctrl[i] = '0;
            tr_err[i]  = 1'b0;
            tr_busy[i] = 1'b0;
        end
        b_msb  = (nz == 0);
        p_top  = ptbl[3:0];
        p_sign = psg;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        while (cyc < 60 && done_cyc < 0) begin
            @(negedge clk);
            tr_ctrl[cyc] = ctrl;
            tr_err[cyc]  = err;
            tr_busy[cyc] = busy;
            for (int b = 0; b < 15; b++) if (ctrl[b]) cnt[b]++;
            if ((ctrl[9] | ctrl[10]) && !ctrl[8]) inv_bad++;
            if ($countones(ctrl[7:4]) > 1 || ((|ctrl[7:4]) && !ctrl[3])) inv_bad++;
            // start stays high for a few cycles; the DUT ignores it while busy.
            if (cyc == 2) start = 1'b0;
            if (ctrl[2]) begin
                n2++;
                if (n2 == nz) b_msb = 1'b1;
            end
            if (ctrl[3]) begin
                n3++;
                if (n3 < 4) p_top = ptbl[4*n3 +: 4];
            end
            if (done) done_cyc = cyc;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({tag, "_invariants"}, 32'(inv_bad), 32'd0);
        $display("[TB] run %s: done at cycle %0d, err=%0b, c2=%0d c3=%0d c14=%0d",
                 tag, done_cyc, err, cnt[2], cnt[3], cnt[14]);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'(ctrl), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err",  32'(err),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Normalized divisor, digit sweep 0111,0010,0000,1110
        run("t2", 0, 16'hE027, 1'b0);
        for (int c = 0; c < 16; c++) check($sformatf("t2_cyc%0d", c), 32'(tr_ctrl[c]), 32'(EXP_A[c]));
        check("t2_done_cyc", 32'(done_cyc), 32'd15);
        check("t2_busy_at_done", 32'(tr_busy[15]), 32'd1);
        check("t2_c3_count", 32'(cnt[3]), 32'd4);
        check("t2_c14_count", 32'(cnt[14]), 32'd0);
        check("t2_err", 32'(tr_err[15]), 32'd0);
        @(negedge clk);
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_done_after", 32'(done), 32'd0);

        // Remaining sweep point 1000 -> digit -2
        run("t4b", 0, 16'h0008, 1'b0);
        check("t4b_sel", 32'(tr_ctrl[4]), 32'h0048);
        check("t4b_add", 32'(tr_ctrl[5]), 32'h0500);
        check("t4b_sel2", 32'(tr_ctrl[6]), 32'h0008);
        check("t4b_add2", 32'(tr_ctrl[7]), 32'h0000);

        // Divide by zero: b_msb held low
        run("t6", 8, 16'h0000, 1'b0);
        check("t6_c2_count", 32'(cnt[2]), 32'd7);
        check("t6_c2_last", 32'(tr_ctrl[9]), 32'h0004);
        check("t6_c3_count", 32'(cnt[3]), 32'd0);
        check("t6_c13_count", 32'(cnt[13]), 32'd0);
        check("t6_err_pre", 32'(tr_err[9]), 32'd0);
        check("t6_err_set", 32'(tr_err[10]), 32'd1);
        check("t6_done_cyc", 32'(done_cyc), 32'd11);
        repeat (3) @(negedge clk);
        check("t6_err_held", 32'(err), 32'd1);

        // Negative remainder -> correction; this start must also clear err
        run("t5", 0, 16'h0000, 1'b1);
        check("t5_err_cleared", 32'(tr_err[0]), 32'd0);
        check("t5_chk", 32'(tr_ctrl[12]), 32'h0000);
        check("t5_corr", 32'(tr_ctrl[13]), 32'h0900);
        check("t5_cinc", 32'(tr_ctrl[14]), 32'h1000);
        check("t5_conv", 32'(tr_ctrl[15]), 32'h2000);
        check("t5_done_cyc", 32'(done_cyc), 32'd17);

        // Three normalize shifts, then three denormalize shifts
        run("t3", 3, 16'h0000, 1'b0);
        check("t3_c2_count", 32'(cnt[2]), 32'd3);
        check("t3_norm_end", 32'(tr_ctrl[6]), 32'h0000);
        check("t3_first_sel", 32'(tr_ctrl[7]), 32'h0008);
        check("t3_conv", 32'(tr_ctrl[16]), 32'h2000);
        check("t3_c14_count", 32'(cnt[14]), 32'd3);
        check("t3_den_a", 32'(tr_ctrl[17]), 32'h4000);
        check("t3_den_c", 32'(tr_ctrl[19]), 32'h4000);
        check("t3_den_end", 32'(tr_ctrl[20]), 32'h0000);
        check("t3_done_cyc", 32'(done_cyc), 32'd21);

        // Reset asserted while ctrl[8] is high
        b_msb = 1'b1;
        p_top = 4'h7;
        p_sign = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        begin
            int k;
            k = 0;
            @(negedge clk);
            start = 1'b0;
            while (!ctrl[8] && k < 30) begin
                @(negedge clk);
                k++;
            end
            check("t1_add_seen", 32'(ctrl[8]), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_ctrl", 32'(ctrl), 32'h0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        $display("[TB] run t1: reset applied during ADD pulse");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_idle_ctrl", 32'(ctrl), 32'h0);
        run("t1_after", 0, 16'hE027, 1'b0);
        check("t1_after_c0", 32'(tr_ctrl[1]), 32'h0001);
        check("t1_after_add", 32'(tr_ctrl[5]), 32'h0700);
        check("t1_after_done", 32'(done_cyc), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
